// File: rtl/csr_timer_bank.sv
// Bank of N_TIMERS down-counting CSR timers with sticky interrupts and a 64-bit
// free-running cycle counter. Each channel owns TCFG, TVAL and TICLR at BASE+4i.
module csr_timer_bank #(
  parameter int          N_TIMERS = 2,
  parameter int          CNT_W    = 32,
  parameter int          INIT_LSB = 2,
  parameter logic [13:0] BASE     = 14'h041
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                csr_we,
  input  logic [13:0]         csr_num,
  input  logic [31:0]         csr_wmask,
  input  logic [31:0]         csr_wvalue,
  input  logic [13:0]         csr_raddr,
  output logic [31:0]         csr_rvalue,
  input  logic                pause,
  output logic [N_TIMERS-1:0] timer_int,
  output logic                timer_int_any,
  output logic [63:0]         stable_cnt
);

  localparam int OFF_TCFG  = 0;
  localparam int OFF_TVAL  = 1;
  localparam int OFF_TICLR = 3;

  // Implemented TCFG bits: EN, PERIODIC and the INITVAL field.
  function automatic logic [31:0] cfg_mask_f();
    logic [31:0] m;
    m = 32'h3;
    for (int b = INIT_LSB; b < CNT_W; b++) m[b] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0]      CFG_MASK = cfg_mask_f();
  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  function automatic logic [13:0] reg_addr(input int ch, input int off);
    return BASE + 14'(4 * ch + off);
  endfunction

  function automatic logic [CNT_W-1:0] reload_of(input logic [31:0] cfg);
    logic [CNT_W-1:0] r;
    r = cfg[CNT_W-1:0];
    for (int b = 0; b < INIT_LSB; b++) r[b] = 1'b0;
    return r;
  endfunction

  logic [N_TIMERS-1:0][31:0]      tcfg_q, tcfg_d;
  logic [N_TIMERS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_TIMERS-1:0]            tint_q, tint_d;
  logic                           any_q, any_d;
  logic [63:0]                    stable_q, stable_d;

  logic        cfg_wr;
  logic        clr_wr;
  logic [31:0] merged;
  logic        en;
  logic        periodic;

  always_comb begin
    tcfg_d   = tcfg_q;
    cnt_d    = cnt_q;
    tint_d   = tint_q;
    cfg_wr   = 1'b0;
    clr_wr   = 1'b0;
    merged   = '0;
    en       = 1'b0;
    periodic = 1'b0;
    for (int i = 0; i < N_TIMERS; i++) begin
      cfg_wr   = csr_we && (csr_num == reg_addr(i, OFF_TCFG));
      clr_wr   = csr_we && (csr_num == reg_addr(i, OFF_TICLR))
                 && csr_wmask[0] && csr_wvalue[0];
      merged   = ((csr_wmask & csr_wvalue) | (~csr_wmask & tcfg_q[i])) & CFG_MASK;
      en       = tcfg_q[i][0];
      periodic = tcfg_q[i][1];

      if (cfg_wr) tcfg_d[i] = merged;

      // An enabling TCFG write reloads immediately, even while paused.
      if (cfg_wr && merged[0]) begin
        cnt_d[i] = reload_of(merged);
      end else if (en && !pause && (cnt_q[i] != CNT_ONES)) begin
        if ((cnt_q[i] == '0) && periodic) cnt_d[i] = reload_of(tcfg_q[i]);
        else                              cnt_d[i] = cnt_q[i] - 1'b1;
      end

      // Set beats clear when both land in the same cycle.
      if (en && (cnt_q[i] == '0)) tint_d[i] = 1'b1;
      else if (clr_wr)            tint_d[i] = 1'b0;
    end
    any_d    = |tint_d;
    stable_d = stable_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_q   <= '0;
      cnt_q    <= '1;
      tint_q   <= '0;
      any_q    <= 1'b0;
      stable_q <= '0;
    end else begin
      tcfg_q   <= tcfg_d;
      cnt_q    <= cnt_d;
      tint_q   <= tint_d;
      any_q    <= any_d;
      stable_q <= stable_d;
    end
  end

  logic [31:0] tval_ext;

  // Reads see registered state only; a same-cycle write is not bypassed.
  always_comb begin
    csr_rvalue = '0;
    tval_ext   = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      if (csr_raddr == reg_addr(i, OFF_TCFG)) begin
        csr_rvalue = tcfg_q[i];
      end else if (csr_raddr == reg_addr(i, OFF_TVAL)) begin
        tval_ext            = '0;
        tval_ext[CNT_W-1:0] = cnt_q[i];
        csr_rvalue          = tval_ext;
      end
    end
  end

  assign timer_int     = tint_q;
  assign timer_int_any = any_q;
  assign stable_cnt    = stable_q;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank: one-shot, periodic, set-vs-clear, pause,
// masked writes, unmapped accesses and reset during countdown.
module tb_csr_timer_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rvalue;
  logic        pause;
  logic [1:0]  timer_int;
  logic        timer_int_any;
  logic [63:0] stable_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] cyc = '0;
  logic [63:0] cyc_mark;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  csr_timer_bank #(
    .N_TIMERS(2), .CNT_W(32), .INIT_LSB(2), .BASE(14'h041)
  ) dut (
    .clk(clk), .reset(reset), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_raddr(csr_raddr),
    .csr_rvalue(csr_rvalue), .pause(pause), .timer_int(timer_int),
    .timer_int_any(timer_int_any), .stable_cnt(stable_cnt)
  );

  always #5 clk = ~clk;

  // Reference cycle count for stable_cnt.
  always @(posedge clk) cyc <= reset ? 64'd0 : cyc + 64'd1;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr_write(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
    tick(1);
    csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
  endtask

  task automatic check_rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
    csr_raddr = a;
    #1;
    expect_eq(tag, 64'(csr_rvalue), 64'(exp));
  endtask

  task automatic check_int(input string tag, input logic [1:0] exp);
    expect_eq({tag, "_int"}, 64'(timer_int), 64'(exp));
    expect_eq({tag, "_any"}, 64'(timer_int_any), 64'(|exp));
  endtask

  initial begin
    reset = 1'b1; csr_we = 1'b0; csr_num = '0; csr_wmask = '0;
    csr_wvalue = '0; csr_raddr = '0; pause = 1'b0;
    tick(2);
    reset = 1'b0;

    // Reset state
    check_int("rst", 2'b00);
    expect_eq("rst_stable", stable_cnt, 64'd0);
    check_rd("rst_tcfg0", 14'h041, 32'h0);
    check_rd("rst_tval0", 14'h042, ONES);
    check_rd("rst_tcfg1", 14'h045, 32'h0);
    check_rd("rst_tval1", 14'h046, ONES);
    check_rd("rst_ticlr0", 14'h044, 32'h0);
    check_rd("unmapped_40", 14'h040, 32'h0);

    // One-shot countdown from 0x10
    csr_write(14'h041, ONES, 32'h0000_0011);
    check_rd("os_load", 14'h042, 32'h10);
    check_rd("os_tcfg", 14'h041, 32'h11);
    tick(16);
    check_rd("os_zero", 14'h042, 32'h0);
    check_int("os_zero", 2'b00);
    tick(1);
    check_int("os_fire", 2'b01);
    check_rd("os_wrap", 14'h042, ONES);
    tick(5);
    check_rd("os_hold", 14'h042, ONES);
    check_int("os_sticky", 2'b01);
    csr_write(14'h044, 32'h1, 32'h1);
    check_int("os_clr", 2'b00);

    // Same-cycle read of a written TCFG returns the old value
    csr_we = 1'b1; csr_num = 14'h041; csr_wmask = ONES; csr_wvalue = 32'h0;
    check_rd("nobypass", 14'h041, 32'h11);
    tick(1);
    csr_we = 1'b0; csr_wmask = '0;
    check_rd("nobypass_after", 14'h041, 32'h0);

    // Periodic, reload 8
    csr_write(14'h041, ONES, 32'h0000_000B);
    check_rd("per_load", 14'h042, 32'h8);
    tick(8);
    check_rd("per_zero", 14'h042, 32'h0);
    check_int("per_zero", 2'b00);
    tick(1);
    check_rd("per_reload", 14'h042, 32'h8);
    check_int("per_fire", 2'b01);
    tick(9);
    check_rd("per_reload2", 14'h042, 32'h8);
    check_int("per_sticky", 2'b01);
    csr_write(14'h044, 32'h1, 32'h1);
    check_int("per_clr", 2'b00);
    check_rd("per_after_clr", 14'h042, 32'h7);
    tick(7);
    check_rd("sw_zero", 14'h042, 32'h0);
    // Clear lands on the zero cycle: set wins
    csr_write(14'h044, 32'h1, 32'h1);
    check_int("set_wins", 2'b01);
    check_rd("set_wins_reload", 14'h042, 32'h8);
    csr_write(14'h044, ONES, 32'h1);
    check_int("per_clr2", 2'b00);
    tick(8);
    check_int("per_reset_fire", 2'b01);
    check_rd("per_reload3", 14'h042, 32'h8);

    // Masked disable: only EN changes
    csr_write(14'h041, 32'h1, 32'h0);
    check_rd("dis_tcfg", 14'h041, 32'h0A);
    check_rd("dis_tval", 14'h042, 32'h7);
    tick(3);
    check_rd("dis_hold", 14'h042, 32'h7);
    csr_write(14'h044, 32'h1, 32'h1);
    check_int("dis_clr", 2'b00);

    // Merged enable picks up INITVAL=3 written while disabled
    csr_write(14'h041, ONES, 32'h0000_000E);
    check_rd("mrg_tcfg_off", 14'h041, 32'h0E);
    check_rd("mrg_tval_off", 14'h042, 32'h7);
    csr_write(14'h041, 32'h1, 32'h1);
    check_rd("mrg_tcfg_on", 14'h041, 32'h0F);
    check_rd("mrg_load", 14'h042, 32'hC);
    tick(12);
    check_rd("mrg_zero", 14'h042, 32'h0);
    tick(1);
    check_rd("mrg_reload", 14'h042, 32'hC);
    check_int("mrg_fire", 2'b01);
    check_rd("iso_tval1", 14'h046, ONES);

    // Pause: ch1 load still happens, both channels freeze, stable_cnt runs
    pause = 1'b1;
    csr_write(14'h045, ONES, 32'h0000_0011);
    cyc_mark = cyc;
    check_rd("pz_load1", 14'h046, 32'h10);
    check_rd("pz_tcfg1", 14'h045, 32'h11);
    expect_eq("pz_stable0", stable_cnt, cyc_mark);
    tick(10);
    check_rd("pz_hold1", 14'h046, 32'h10);
    check_rd("pz_hold0", 14'h042, 32'hC);
    expect_eq("pz_stable10", stable_cnt, cyc_mark + 64'd10);
    pause = 1'b0;
    tick(1);
    check_rd("pz_run1", 14'h046, 32'hF);
    check_rd("pz_run0", 14'h042, 32'hB);
    check_int("pz_int", 2'b01);

    // Unmapped writes have no effect
    csr_write(14'h043, ONES, ONES);
    csr_write(14'h047, ONES, ONES);
    check_rd("unm_tcfg0", 14'h041, 32'h0F);
    check_rd("unm_tcfg1", 14'h045, 32'h11);
    check_rd("unm_tval1", 14'h046, 32'hD);
    check_rd("unm_tval0", 14'h042, 32'h9);
    check_rd("unm_rd43", 14'h043, 32'h0);

    // Reset mid-countdown
    reset = 1'b1;
    csr_we = 1'b1; csr_num = 14'h041; csr_wmask = ONES; csr_wvalue = 32'h11;
    tick(1);
    reset = 1'b0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    check_int("mrst", 2'b00);
    check_rd("mrst_tval0", 14'h042, ONES);
    check_rd("mrst_tcfg0", 14'h041, 32'h0);
    check_rd("mrst_tval1", 14'h046, ONES);
    check_rd("mrst_tcfg1", 14'h045, 32'h0);
    expect_eq("mrst_stable", stable_cnt, 64'd0);
    tick(3);
    expect_eq("stable_run", stable_cnt, 64'd3);
    expect_eq("stable_model", stable_cnt, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_timer_bank.md
CSR_TIMER_BANK -- requirements
Module: csr_timer_bank

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL provide the following parameters (name, default, meaning):
- N_TIMERS, 2, number of independent timer channels (1..8).
- CNT_W, 32, counter width (16..32).
- INIT_LSB, 2, low bits of the reload value forced to zero.
- BASE, 14'h041, CSR number of TCFG for channel 0.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- csr_we, in, 1, CSR write enable.
- csr_num, in, 14, CSR write address.
- csr_wmask, in, 32, per-bit write mask.
- csr_wvalue, in, 32, write data.
- csr_raddr, in, 14, CSR read address.
- csr_rvalue, out, 32, read data (combinational).
- pause, in, 1, freezes all channel counters while high.
- timer_int, out, N_TIMERS, per-channel interrupt pending.
- timer_int_any, out, 1, OR of timer_int.
- stable_cnt, out, 64, free-running cycle counter.

Function
REQ-004 Channel i SHALL map TCFG at BASE+4i, TVAL (read-only) at BASE+4i+1 and TICLR (write-1-to-clear, reads 0) at BASE+4i+3.
REQ-005 TCFG SHALL be laid out as: bit0 EN, bit1 PERIODIC, bits[CNT_W-1:INIT_LSB] INITVAL; all other bits read 0 and ignore writes.
REQ-006 Every CSR write SHALL apply new = (wmask & wvalue) | (~wmask & old), bitwise.
REQ-007 A TCFG write whose merged EN bit is 1 SHALL load cnt_i = {INITVAL_new, INIT_LSB zeros} on the next edge, overriding decrement and pause.
REQ-008 When EN=1, pause=0 and cnt_i != all-ones, each cycle SHALL do: if cnt_i==0 and PERIODIC then cnt_i <= reload value, else cnt_i <= cnt_i-1.
REQ-009 In one-shot mode, decrement from 0 SHALL wrap cnt_i to all-ones, and the counter SHALL then hold until reloaded by REQ-007.
REQ-010 The counter SHALL hold its value when EN=0 or pause=1.
REQ-011 timer_int[i] SHALL be set on the edge following any cycle with EN=1 and cnt_i==0; pause does not mask this.
REQ-012 timer_int[i] SHALL clear on the edge after a TICLR_i write with wmask[0]&wvalue[0]=1.
REQ-013 If a set condition and a clear write occur in the same cycle, set SHALL win.
REQ-014 TVAL_i SHALL read cnt_i zero-extended to 32 bits.
REQ-015 Reads SHALL return pre-write register state in the cycle of a write to the same address (no bypass).
REQ-016 Unmapped csr_raddr SHALL read 32'h0.
REQ-017 Writes to unmapped csr_num SHALL have no effect.
REQ-018 Each channel's writes SHALL affect only that channel.
REQ-019 stable_cnt SHALL increment by 1 every cycle regardless of pause, and SHALL wrap from all-ones to 0.
REQ-020 timer_int and timer_int_any SHALL be registered outputs; timer_int_any SHALL equal |timer_int in the same cycle.

Reset
REQ-021 In any cycle with reset=1, on the edge the block SHALL set: EN=0, PERIODIC=0, INITVAL=0, cnt_i=all-ones, timer_int=0, stable_cnt=0.
REQ-022 Reset SHALL take priority over every write and count operation, including mid-countdown.
REQ-023 After reset, csr_rvalue for TCFG_i SHALL read 0 and TVAL_i SHALL read {CNT_W{1}}.

Verification (N_TIMERS=2, CNT_W=32, INIT_LSB=2, BASE=14'h041)
REQ-024 Scenario: write 14'h041 = 32'h0000_0011, mask all-ones -> TVAL reads 0x10 next cycle, reaches 0 sixteen cycles later, timer_int[0]=1 one cycle after that, and TVAL then reads 0xFFFF_FFFF and holds.
REQ-025 Scenario: write 14'h041 = 32'h0000_000B -> counts 8..0, reloads to 8; timer_int[0] stays 1 until a write of 14'h044 = 1, then it re-sets at the next zero.
REQ-026 Scenario: write TICLR in the exact cycle cnt==0 with EN=1 -> timer_int[0] remains 1 (set wins).
REQ-027 Scenario: channel 1 (14'h045) started with INITVAL=4 while pause=1 for 10 cycles -> TVAL at 14'h046 holds 0x10 and stable_cnt advances by 10.
REQ-028 Scenario: write 14'h041 with wmask=32'h1 and wvalue=1 after PERIODIC=1, INITVAL=3 were set with EN=0 -> counter loads 0xC (merged value) and runs periodic.
REQ-029 Scenario: assert reset during an active countdown -> next cycle timer_int=0, TVAL=0xFFFF_FFFF, TCFG=0, stable_cnt=0.
